// File: rtl/alu_bus_rr_arbiter_pkg.sv
// Shared definitions for the ALU result-mux round-robin arbiter:
// state encoding, width helper and the legal requester counts.
package alu_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    localparam int N_LEGAL_A = 16;
    localparam int N_LEGAL_B = 32;

    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) w++;
        return (w < 1) ? 1 : w;
    endfunction

    function automatic bit legal_n(input int n);
        return (n == N_LEGAL_A) || (n == N_LEGAL_B);
    endfunction

endpackage

// File: rtl/alu_bus_rr_arbiter_if.sv
// Request/select bundle between the requesting units and the arbiter.
// The master side raises requests; the slave side (arbiter) drives the mux select.
interface alu_bus_rr_arbiter_if #(
    parameter int N = 16
);
    localparam int IDX_W = $clog2(N);

    logic [N-1:0]     req;
    logic [N-1:0]     sel;
    logic [IDX_W-1:0] grant_id;
    logic             busy;

    modport master (output req, input sel, input grant_id, input busy);
    modport slave  (input req, output sel, output grant_id, output busy);
endinterface

// File: rtl/alu_bus_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of (req & ~mask)
// searching start, start+1, ... wrapping modulo N.
module rr_pick
    import alu_arb_pkg::*;
#(
    parameter  int N     = 16,
    localparam int IDX_W = clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     mask,
    input  logic [IDX_W-1:0] start,
    output logic             found,
    output logic [IDX_W-1:0] idx,
    output logic [N-1:0]     onehot
);

    logic [N-1:0]     cand;
    logic [2*N-1:0]   dbl;
    logic [N-1:0]     rot;
    logic [IDX_W-1:0] ffs;

    always_comb begin
        cand = req & ~mask;
        // Doubling the vector turns the right-rotate into a plain shift.
        dbl  = {cand, cand} >> start;
        rot  = dbl[N-1:0];
        found = |rot;
        ffs = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) ffs = IDX_W'(i);
        end
        // N is a power of two, so the IDX_W-bit add wraps modulo N for free.
        idx    = ffs + start;
        onehot = found ? (N'(1) << idx) : '0;
    end

endmodule

// File: rtl/alu_bus_rr_arbiter.sv
// Round-robin owner of the ALU result mux select: holds a grant while requested,
// hands over back-to-back on release or hold timeout, all outputs registered.
module alu_bus_rr_arbiter
    import alu_arb_pkg::*;
#(
    parameter  int N        = 16,
    parameter  int MAX_HOLD = 4,
    localparam int IDX_W    = clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_bus_rr_arbiter_if.slave bus
);

    localparam int HC_W      = (MAX_HOLD > 1) ? clog2(MAX_HOLD) : 1;
    localparam int HOLD_LAST = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;

    if (!legal_n(N)) begin : g_bad_n
        $error("alu_bus_rr_arbiter: N must be 16 or 32");
    end

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [HC_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [N-1:0]     sel_q, sel_d;
    logic [IDX_W-1:0] gid_q, gid_d;
    logic             busy_q, busy_d;

    logic [N-1:0]     pick_mask;
    logic [IDX_W-1:0] pick_start;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic [N-1:0]     pick_onehot;
    logic             released;
    logic             timeout;

    // Owner bit is masked while granted; on release it is already low, so the
    // same search serves both the release and the timeout handover.
    assign pick_mask  = (state_q == ARB_GRANT) ? sel_q : '0;
    assign pick_start = (state_q == ARB_GRANT) ? gid_q + IDX_W'(1) : ptr_q;
    assign released   = ~bus.req[gid_q];
    assign timeout    = (MAX_HOLD != 0) && (hold_cnt_q == HC_W'(HOLD_LAST));

    rr_pick #(.N(N)) u_pick (
        .req    (bus.req),
        .mask   (pick_mask),
        .start  (pick_start),
        .found  (pick_found),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        sel_d      = sel_q;
        gid_d      = gid_q;

        case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    state_d    = ARB_GRANT;
                    sel_d      = pick_onehot;
                    gid_d      = pick_idx;
                    hold_cnt_d = '0;
                end
            end
            ARB_GRANT: begin
                if (released) begin
                    ptr_d      = gid_q + IDX_W'(1);
                    hold_cnt_d = '0;
                    if (pick_found) begin
                        sel_d = pick_onehot;
                        gid_d = pick_idx;
                    end else begin
                        state_d = ARB_IDLE;
                        sel_d   = '0;
                        gid_d   = '0;
                    end
                end else if (timeout) begin
                    hold_cnt_d = '0;
                    // With no other requester the grant is renewed in place.
                    if (pick_found) begin
                        ptr_d = gid_q + IDX_W'(1);
                        sel_d = pick_onehot;
                        gid_d = pick_idx;
                    end
                end else if (MAX_HOLD != 0) begin
                    hold_cnt_d = hold_cnt_q + HC_W'(1);
                end
            end
            default: begin
                state_d = ARB_IDLE;
                sel_d   = '0;
                gid_d   = '0;
            end
        endcase

        busy_d = |sel_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ARB_IDLE;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            sel_q      <= '0;
            gid_q      <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            sel_q      <= sel_d;
            gid_q      <= gid_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.sel      = sel_q;
    assign bus.grant_id = gid_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_alu_bus_rr_arbiter.sv
// Directed bench for the round-robin mux arbiter: N=16/MAX_HOLD=4 main DUT
// plus an N=32 unlimited-hold instance, with per-cycle select invariants.
module tb_alu_bus_rr_arbiter;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;
    bit   inv_en;

    alu_bus_rr_arbiter_if #(.N(16)) bus16 ();
    alu_bus_rr_arbiter_if #(.N(32)) bus32 ();

    alu_bus_rr_arbiter #(.N(16), .MAX_HOLD(4)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16)
    );

    alu_bus_rr_arbiter #(.N(32), .MAX_HOLD(0)) dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic logic [31:0] idx_of(input logic [31:0] v);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) if (v[i]) r = 32'(i);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (inv_en) begin
            chk("onehot16", 32'($onehot0(bus16.sel)), 32'd1);
            chk("gid16",    32'(bus16.grant_id), idx_of(32'(bus16.sel)));
            chk("busy16",   32'(bus16.busy), 32'(|bus16.sel));
            chk("onehot32", 32'($onehot0(bus32.sel)), 32'd1);
            chk("gid32",    32'(bus32.grant_id), idx_of(bus32.sel));
            chk("busy32",   32'(bus32.busy), 32'(|bus32.sel));
        end
    end

    initial begin
        logic [15:0] exp3 [12];
        n_chk  = 0;
        n_pass = 0;
        inv_en = 1'b0;
        rst_n  = 1'b0;
        bus16.req = '0;
        bus32.req = '0;
        #1;

        // 1: reset with all requesting, then bit 0 wins from ptr 0
        bus16.req = 16'hFFFF;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_sel",  32'(bus16.sel), 32'h0);
            chk("rst_gid",  32'(bus16.grant_id), 32'd0);
            chk("rst_busy", 32'(bus16.busy), 32'd0);
        end
        inv_en = 1'b1;
        rst_n  = 1'b1;
        tick();
        chk("rst_first_sel",  32'(bus16.sel), 32'h0001);
        chk("rst_first_busy", 32'(bus16.busy), 32'd1);
        bus16.req = '0;
        tick();
        chk("rst_idle", 32'(bus16.sel), 32'h0);

        // 2: single requester, release, ptr moves to 6
        bus16.req = 16'h0020;
        tick();
        chk("single_sel", 32'(bus16.sel), 32'h0020);
        chk("single_gid", 32'(bus16.grant_id), 32'd5);
        tick();
        tick();
        chk("single_hold", 32'(bus16.sel), 32'h0020);
        bus16.req = '0;
        tick();
        chk("single_rel", 32'(bus16.sel), 32'h0);
        chk("single_rel_busy", 32'(bus16.busy), 32'd0);
        bus16.req = 16'h0050;
        tick();
        chk("ptr6_sel", 32'(bus16.sel), 32'h0040);
        chk("ptr6_gid", 32'(bus16.grant_id), 32'd6);
        // other requesters must not disturb an unexpired grant
        bus16.req = 16'h00D0;
        tick();
        chk("no_steal", 32'(bus16.sel), 32'h0040);
        bus16.req = '0;
        tick();

        // 3: contention after reset, strict 4/4 alternation
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus16.req = 16'h8001;
        exp3 = '{16'h0001, 16'h0001, 16'h0001, 16'h0001,
                 16'h8000, 16'h8000, 16'h8000, 16'h8000,
                 16'h0001, 16'h0001, 16'h0001, 16'h0001};
        for (int i = 0; i < 12; i++) begin
            tick();
            chk($sformatf("cont_%0d", i), 32'(bus16.sel), 32'(exp3[i]));
        end
        bus16.req = '0;
        tick();

        // 4: lone requester renews at timeout without a gap
        bus16.req = 16'h0004;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk($sformatf("renew_%0d", i), 32'(bus16.sel), 32'h0004);
        end
        bus16.req = '0;
        tick();

        // 5: release of bit 15 wraps the search to bit 0
        bus16.req = 16'h8000;
        tick();
        chk("wrap_own15", 32'(bus16.sel), 32'h8000);
        bus16.req = 16'h4001;
        tick();
        chk("wrap_sel",  32'(bus16.sel), 32'h0001);
        chk("wrap_busy", 32'(bus16.busy), 32'd1);
        bus16.req = '0;
        tick();

        // 6: reset mid-grant clears sel and ptr
        bus16.req = 16'h0100;
        tick();
        chk("midrst_own", 32'(bus16.sel), 32'h0100);
        rst_n = 1'b0;
        bus16.req = 16'h0101;
        tick();
        chk("midrst_sel",  32'(bus16.sel), 32'h0);
        chk("midrst_busy", 32'(bus16.busy), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("midrst_after", 32'(bus16.sel), 32'h0001);
        bus16.req = '0;

        // N=32, unlimited hold: no timeout, then wrap 31 -> 0
        bus32.req = 32'h8000_0001;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("n32_hold_%0d", i), bus32.sel, 32'h0000_0001);
        end
        bus32.req = 32'h8000_0000;
        tick();
        chk("n32_hand",     bus32.sel, 32'h8000_0000);
        chk("n32_hand_gid", 32'(bus32.grant_id), 32'd31);
        bus32.req = 32'h0000_0001;
        tick();
        chk("n32_wrap", bus32.sel, 32'h0000_0001);
        bus32.req = '0;
        tick();
        chk("n32_idle", bus32.sel, 32'h0);

        inv_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
